// File: rtl/uart_rx_serial.sv
// ============================================================================
// Module   : uart_rx_serial
// Brief    : 8-bit LSB-first UART receiver producing byte strobes for the
//            Sobel datapath. Define UART_RX_PARITY_EN for 8E1 framing,
//            otherwise the frame is 8N1 and erro_paridade is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_serial #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] rx_dados,
    output logic       rx_pronto,
    output logic       erro_frame,
    output logic       erro_paridade,
    output logic       ocupado
);

    localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
    localparam int SW = 9;
`else
    localparam int SW = 8;
`endif

    localparam logic [CW-1:0] C_BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic          sync1_q;
    logic          rx_s_q;
    logic [2:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [2:0]    idx_q,    idx_d;
    logic [SW-1:0] shift_q,  shift_d;
    logic [7:0]    dados_q,  dados_d;
    logic          pronto_q, pronto_d;
    logic          ferr_q,   ferr_d;
    logic          perr_q,   perr_d;
    logic          w_bit_end;
    logic          w_parity_ok;

    assign w_bit_end = (cnt_q == C_BIT_END);

`ifdef UART_RX_PARITY_EN
    // Even parity: the nine received bits must XOR to zero.
    assign w_parity_ok = ~(^shift_q);
`else
    assign w_parity_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        dados_d  = dados_q;
        pronto_d = 1'b0;
        ferr_d   = 1'b0;
        perr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == C_HALF_END) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    cnt_d      = '0;
                    shift_d[8] = rx_s_q;
                    state_d    = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end else if (w_parity_ok) begin
                        dados_d  = shift_q[7:0];
                        pronto_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        perr_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            rx_s_q   <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            dados_q  <= 8'h00;
            pronto_q <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            sync1_q  <= rx_serial;
            rx_s_q   <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            dados_q  <= dados_d;
            pronto_q <= pronto_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
        end
    end

    assign rx_dados   = dados_q;
    assign rx_pronto  = pronto_q;
    assign erro_frame = ferr_q;
    assign ocupado    = (state_q != S_IDLE);

`ifdef UART_RX_PARITY_EN
    assign erro_paridade = perr_q;
`else
    assign erro_paridade = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_serial.sv
// ============================================================================
// Module   : tb_uart_rx_serial
// Brief    : Self-checking bench for uart_rx_serial with a byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_serial;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clock;
    logic       reset;
    logic       rx_serial;
    logic [7:0] rx_dados;
    logic       rx_pronto;
    logic       erro_frame;
    logic       erro_paridade;
    logic       ocupado;

    uart_rx_serial #(.CLKS_PER_BIT(CPB)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_serial     (rx_serial),
        .rx_dados      (rx_dados),
        .rx_pronto     (rx_pronto),
        .erro_frame    (erro_frame),
        .erro_paridade (erro_paridade),
        .ocupado       (ocupado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pflip;
        logic       exp_ok;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         n_pronto = 0;
    int         n_ferr   = 0;
    int         n_perr   = 0;
    logic       prev_pronto = 1'b0;
    logic [7:0] exp_q[$];
    int         pronto_times[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc++;

    // Scoreboard side: every strobe pops the oldest expected byte.
    always @(negedge clock) begin
        if (!reset) begin
            if (rx_pronto) begin
                n_pronto++;
                pronto_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_pronto", 32'd1, 32'd0);
                end else begin
                    check("rx_dados_on_pronto", rx_dados, exp_q.pop_front());
                end
            end
            if (erro_frame)    n_ferr++;
            if (erro_paridade) n_perr++;
            if (rx_pronto || erro_frame || erro_paridade)
                check("pulse_exclusive", 32'(rx_pronto) + 32'(erro_frame) + 32'(erro_paridade), 32'd1);
            if (prev_pronto)
                check("pronto_width", rx_pronto, 1'b0);
            prev_pronto = rx_pronto;
        end
    end

    task automatic send_bit(input logic v);
        rx_serial = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ pflip);
`endif
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rx_serial = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    vec_t       vecs[8];
    int         nvec;
    logic [7:0] last_good;
    int         p0, f0, e0;

    initial begin
        nvec = 0;
        vecs[nvec++] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[nvec++] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[nvec++] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[nvec++] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[nvec++] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef UART_RX_PARITY_EN
        vecs[nvec++] = '{8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[nvec++] = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

        reset     = 1'b1;
        rx_serial = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clock);
        check("reset_rx_dados", rx_dados, 8'h00);
        check("reset_rx_pronto", rx_pronto, 1'b0);
        check("reset_erro_frame", erro_frame, 1'b0);
        check("reset_erro_paridade", erro_paridade, 1'b0);
        check("reset_ocupado", ocupado, 1'b0);
        reset = 1'b0;
        idle(4);

        for (int v = 0; v < nvec; v++) begin
            p0 = n_pronto; f0 = n_ferr; e0 = n_perr;
            if (vecs[v].exp_ok) begin
                exp_q.push_back(vecs[v].data);
                last_good = vecs[v].data;
            end
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].pflip);
            if (vecs[v].exp_ok) check("ocupado_after_stop", ocupado, 1'b0);
            idle(2 * CPB);
            check("vec_pronto_count", n_pronto - p0, 32'(vecs[v].exp_ok));
            check("vec_ferr_count", n_ferr - f0, 32'(vecs[v].exp_ferr));
            check("vec_perr_count", n_perr - e0, 32'(vecs[v].exp_perr));
            check("vec_rx_dados_hold", rx_dados, last_good);
            check("vec_ocupado_idle", ocupado, 1'b0);
        end

        // Back-to-back frames with no idle bits between them.
        p0 = n_pronto;
        pronto_times.delete();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h12);
        exp_q.push_back(8'hF0); exp_q.push_back(8'h0F);
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        last_good = 8'h0F;
        idle(2 * CPB);
        check("b2b_count", n_pronto - p0, 32'd4);
        if (pronto_times.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("b2b_spacing", pronto_times[i] - pronto_times[i-1], FRAME_BITS * CPB);
        end else begin
            check("b2b_times_recorded", pronto_times.size(), 32'd4);
        end

        // Start-bit glitch of three cycles.
        p0 = n_pronto; f0 = n_ferr;
        rx_serial = 1'b0;
        repeat (3) @(negedge clock);
        idle(3 * CPB);
        check("glitch_no_pronto", n_pronto - p0, 32'd0);
        check("glitch_no_ferr", n_ferr - f0, 32'd0);
        check("glitch_ocupado", ocupado, 1'b0);
        check("glitch_rx_dados", rx_dados, last_good);

        // Stop bit low, then line stuck low for 40 more cycles.
        p0 = n_pronto; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx_serial = 1'b0;
        repeat (40) @(negedge clock);
        check("break_ocupado_held", ocupado, 1'b1);
        idle(2 * CPB);
        check("break_ferr_count", n_ferr - f0, 32'd1);
        check("break_no_pronto", n_pronto - p0, 32'd0);
        check("break_rx_dados", rx_dados, last_good);
        exp_q.push_back(8'h77);
        last_good = 8'h77;
        send_frame(8'h77, 1'b1, 1'b0);
        idle(2 * CPB);
        check("after_break_rx_dados", rx_dados, 8'h77);
        check("after_break_pronto", n_pronto - p0, 32'd1);

        // Reset in the middle of data bit 4 of 0x5A.
        p0 = n_pronto;
        begin
            logic [7:0] b;
            b = 8'h5A;
            send_bit(1'b0);
            for (int i = 0; i < 4; i++) send_bit(b[i]);
            rx_serial = b[4];
            repeat (CPB / 2) @(negedge clock);
        end
        reset = 1'b1;
        #1;
        check("midreset_rx_dados", rx_dados, 8'h00);
        check("midreset_ocupado", ocupado, 1'b0);
        check("midreset_pronto", rx_pronto, 1'b0);
        rx_serial = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        idle(2 * CPB);
        check("midreset_no_pronto", n_pronto - p0, 32'd0);
        check("midreset_dados_zero", rx_dados, 8'h00);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(2 * CPB);
        check("after_reset_rx_dados", rx_dados, 8'hC3);
        check("after_reset_pronto", n_pronto - p0, 32'd1);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_serial.md
# uart_rx_serial

Serial UART receiver (8 data bits, LSB first, 1 stop bit, no parity by default) that turns the host's serial line into byte-wide writes for the Sobel processing datapath. It sits directly upstream of the datapath. Its `rx_dados`/`rx_pronto` outputs connect one-to-one to the datapath inputs of the same names. Each byte carries two 4-bit pixels and advances the image write pointer by one position.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit period (50 MHz / 115200 baud); must be ≥ 4.
- `clock`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high; returns block to IDLE immediately.
- `rx_serial`  input  1  asynchronous serial line; idle level 1.
- `rx_dados`  output  8  last correctly received byte; holds until next good frame.
- `rx_pronto`  output  1  one-cycle pulse: `rx_dados` just updated with a valid byte.
- `erro_frame`  output  1  one-cycle pulse: stop bit sampled low.
- `erro_paridade`  output  1  one-cycle pulse: parity mismatch (constant 0 without parity).
- `ocupado`  output  1  high whenever state ≠ IDLE.

## Operation
- Input synchronizer: 2-flop chain on `rx_serial`, both flops reset to 1; all logic uses the second-stage output `rx_s`.
- Bit-period counter: counts 0..CLKS_PER_BIT-1; 9-bit shift register; 3-bit bit index.
- States: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
- IDLE
  - Waits for `rx_s` = 0.
  - On detection: clear counter, go to START.
- START
  - At counter = CLKS_PER_BIT/2 − 1 (integer divide), sample `rx_s`.
  - 0: clear counter, go to DATA.
  - 1: glitch; back to IDLE, no output activity.
- DATA
  - At counter = CLKS_PER_BIT − 1, sample `rx_s` into bit [index] (LSB first).
  - After bit 7: go to STOP, or to PARITY when parity is compiled in.
- PARITY: sample one bit period later, compare against the parity of the 8 data bits.
- STOP
  - Sample one bit period later.
  - Sample 1 and parity OK: load `rx_dados`, pulse `rx_pronto`, go to IDLE.
  - Sample 1 and parity bad: pulse `erro_paridade`, `rx_dados` unchanged, go to IDLE.
  - Sample 0: pulse `erro_frame`, `rx_dados` unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stays until `rx_s` = 1 (break/stuck-low line), then IDLE. No new start is detected while here.
- At most one of `rx_pronto`/`erro_frame`/`erro_paridade` is high in any cycle.

## Timing
- Reset values:
  - `rx_dados` = 8'h00; `rx_pronto`, `erro_frame`, `erro_paridade`, `ocupado` = 0.
  - State IDLE; counter and bit index 0; synchronizer flops = 1.
- Input latency: a falling edge on `rx_serial` reaches `rx_s` 2 cycles later.
- Sampling: every sample lands at the bit-period midpoint ±1 cycle.
- Output timing: `rx_pronto` rises on the edge that samples the stop bit and is high for exactly 1 cycle. `rx_dados` is valid in that same cycle and stays stable afterward.
- Back-to-back frames: the return to IDLE happens at mid-stop-bit. A start bit that follows immediately after the stop bit is detected with no lost byte.
- Reset asserted mid-frame:
  - Partial byte discarded; no pulse generated.
  - `rx_dados` returns to 00.
  - After release, the block waits for a fresh falling edge.
- Downstream contract: `rx_pronto` is a single-cycle strobe. The downstream stage must not need a handshake back, and there is no back-pressure. The minimum spacing between strobes is 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with parity).

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state compiled in; frame is 8E1 (even parity, bit after D7).
  - `erro_paridade` is live.
- Undefined:
  - Frame is 8N1; PARITY state and its logic are absent.
  - `erro_paridade` is tied 0.

## Test plan
- CLKS_PER_BIT = 8. Send 0xA5 as 8N1 → exactly one `rx_pronto` pulse, `rx_dados` = A5; `ocupado` low again after the stop-bit midpoint.
- Send 0xA5, 0x12, 0xF0, 0x0F back-to-back with zero idle bits → four `rx_pronto` pulses in order A5, 12, F0, 0F, spaced 80 cycles apart.
- Drive `rx_serial` low for 3 cycles, then high → no pulses, state returns to IDLE, `rx_dados` unchanged.
- Send 0x3C with the stop bit forced low, and hold the line low for 40 more cycles → one `erro_frame` pulse; no `rx_pronto`; `rx_dados` keeps the prior value; next good 0x77 received correctly after the line returns high.
- Assert `reset` during data bit 4 of 0x5A → outputs reset immediately; no pulse; subsequent 0xC3 received correctly.
- With `UART_RX_PARITY_EN`:
  - 0x12 with correct parity bit 0 → `rx_pronto`, `rx_dados` = 12.
  - 0x12 with parity bit 1 → `erro_paridade` pulse only.
